cordic_topolar_seq: RTL and testbench
=====================================

Name: cordic_topolar_seq

Overview:
- Iterative vectoring-mode CORDIC: converts a signed rectangular sample (x, y) into unsigned magnitude and phase, one micro-rotation per clock.
- It is the inverse-direction companion to the rotation-mode CORDIC path, using the same phase convention: PW-bit unsigned fraction of a full turn, 0x400000 = 90° at PW=24.
- Sits after the demodulator/mixer to extract amplitude and phase of the tracked tone.
- Simple strobe/busy handshake; the core is time-shared across iterations, with no pipeline.

Parameters:
- IW, 12, input sample width (signed).
- WW, 16, internal working width. WW >= IW+3: 2 guard bits plus at least 1 fractional bit.
- PW, 24, phase width; a full turn = 2^PW.
- NSTAGES, 14, number of CORDIC iterations. Range 1..WW-2.
- OW, 13, magnitude output width (unsigned, IW+1).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_stb  in  1  input-valid strobe; sampled only when o_busy=0
- i_xval  in  IW  signed in-phase input
- i_yval  in  IW  signed quadrature input
- o_busy  out  1  high while a conversion is in progress
- o_done  out  1  one-cycle pulse: o_mag/o_phase are newly valid
- o_mag  out  OW  unsigned magnitude, scaled by CORDIC gain (~1.64676)
- o_phase  out  PW  atan2(y, x) as a fraction of a turn, modulo 2^PW

Behaviour:
- Reset (synchronous, i_reset=1 at a clock edge):
  - state IDLE; o_busy=0, o_done=0, o_mag=0, o_phase=0.
  - Internal x/y/phase/counter registers cleared.
  - Reset overrides any conversion in progress; a partial result is never emitted.
- States: IDLE -> ITER -> DONE -> IDLE.
- Accept:
  - At edge T, if state=IDLE and i_stb=1, latch the input and go to ITER with counter k=0, o_busy=1.
  - i_stb while busy is ignored; no queuing.
- Sign extension: F = WW-IW-2. e = {2 copies of sign, input, F zeros}.
- Pre-rotation at accept:
  - If i_xval < 0: x = -ex, y = -ey, ph = 2^(PW-1).
  - Else: x = ex, y = ey, ph = 0.
  - Result: x >= 0 and the residual angle lies in [-90°, +90°].
- ITER, one iteration per edge for k = 0..NSTAGES-1. All shifts are arithmetic.
  - If y >= 0: x += y>>>k; y -= x>>>k; ph += A[k].
  - Else: x -= y>>>k; y += x>>>k; ph -= A[k].
  - The right-hand sides use the pre-update x/y values (simultaneous update).
  - ph wraps modulo 2^PW.
- Arctan table: A[k] = round(atan(2^-k) / (2π) * 2^PW), a constant table computed at elaboration. A[0] = 2^(PW-3) (0x200000).
- After the edge that performs iteration NSTAGES-1, go to DONE.
- DONE, one edge:
  - o_phase = ph.
  - o_mag = (x + 2^(F-1)) >> F, saturated to 2^OW-1. With F=0, no rounding is applied.
  - o_done=1 for exactly one cycle; o_busy=0; return to IDLE.
- Latency and throughput:
  - Accept at edge T; o_done is high during the cycle after edge T+NSTAGES+1.
  - The earliest next accept is edge T+NSTAGES+2, so throughput is one result per NSTAGES+2 cycles.
- o_mag/o_phase hold their value until the next DONE or reset.
- Width safety: max |x| = 1.64676 × √2 × 2^(IW-1) × 2^F fits in WW bits signed. There is no internal overflow for any input, including (-2^(IW-1), -2^(IW-1)).
- Input (0,0): o_mag=0. o_phase is deterministic but undefined.

Test Plan:
- Reset, then idle for 20 cycles -> o_busy=0, o_done=0, o_mag=0, o_phase=0 throughout.
- (1000,0) -> o_done exactly 16 cycles after the accept edge; o_mag=1647±2; o_phase within ±0x1000 of 0 (mod 2^24).
- (0,1000) -> o_mag=1647±2, o_phase ≈0x400000±0x1000. (-1000,0) -> o_phase ≈0x800000±0x1000. (0,-1000) -> o_phase ≈0xC00000±0x1000.
- (-2048,-2048) extreme corner -> o_mag=4770±3 with no overflow or saturation artefacts; o_phase ≈0xA00000±0x1000.
- i_stb held high continuously with changing data -> only the samples at idle edges are taken; o_done pulses are spaced exactly 16 cycles apart; each result matches the sample accepted.
- Assert i_reset mid-ITER (k=5) -> next cycle o_busy=0 with no o_done pulse, outputs zero; a new i_stb then converts correctly.

Source files
------------

// File: rtl/cordic_topolar_seq.sv
// Iterative vectoring CORDIC: signed (x,y) -> gain-scaled magnitude and phase as a fraction of a turn.
// Latency: sample accepted at edge T, o_done high in the cycle after edge T+NSTAGES+1.
// Backpressure: i_stb is ignored while o_busy=1 (no queuing); one result per NSTAGES+2 cycles.
module cordic_topolar_seq #(
  parameter int IW      = 12,
  parameter int WW      = 16,
  parameter int PW      = 24,
  parameter int NSTAGES = 14,
  parameter int OW      = 13
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stb,
  input  logic signed [IW-1:0] i_xval,
  input  logic signed [IW-1:0] i_yval,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [OW-1:0]        o_mag,
  output logic [PW-1:0]        o_phase
);

  // Fractional bits appended below the input sample inside the working registers.
  localparam int F   = WW - IW - 2;
  localparam int KW  = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam int RSH = (F > 0) ? F - 1 : 0;
  localparam logic [WW:0]   RND       = (F > 0) ? ((WW+1)'(1) << RSH) : '0;
  localparam logic [WW:0]   MAG_MAX   = (WW+1)'((1 << OW) - 1);
  localparam logic [PW-1:0] HALF_TURN = PW'(1) << (PW - 1);

  typedef logic [NSTAGES-1:0][PW-1:0] atan_tbl_t;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  // atan(2^-k) as a fraction of a turn scaled by 2^32. Beyond k=13 the
  // small-angle form 2^32/(2*pi) * 2^-k is exact to well under one LSB.
  function automatic logic [31:0] atan32(input int k);
    case (k)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      default: return (32'd683565276 + (32'd1 << (k - 1))) >> k;
    endcase
  endfunction

  // Round the 32-bit turn fraction to PW bits (PW up to 31).
  function automatic logic [PW-1:0] atan_pw(input int k);
    logic [32:0] a;
    a = {1'b0, atan32(k)} + (33'd1 << (31 - PW));
    return PW'(a >> (32 - PW));
  endfunction

  function automatic atan_tbl_t build_tbl();
    atan_tbl_t t;
    for (int k = 0; k < NSTAGES; k++) t[k] = atan_pw(k);
    return t;
  endfunction

  localparam atan_tbl_t ATAN_TBL = build_tbl();

  state_t               state_q, state_d;
  logic signed [WW-1:0] x_q, x_d, y_q, y_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic [KW-1:0]        k_q, k_d;
  logic [OW-1:0]        mag_q, mag_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 done_q, done_d;

  logic signed [WW-1:0] ex, ey, xs, ys;
  logic [WW:0]          xr, xsh;
  logic [OW-1:0]        mag_sat;

  // Inputs sign-extended by two guard bits and padded with F fractional zeros.
  assign ex = WW'(i_xval) <<< F;
  assign ey = WW'(i_yval) <<< F;
  assign xs = x_q >>> k_q;
  assign ys = y_q >>> k_q;

  // x is non-negative after pre-rotation, so the extra top bit only guards the rounding add.
  assign xr      = {1'b0, x_q} + RND;
  assign xsh     = xr >> F;
  assign mag_sat = (xsh > MAG_MAX) ? {OW{1'b1}} : xsh[OW-1:0];

  // State and datapath registers; reset drops any conversion in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ph_q    <= '0;
      k_q     <= '0;
      mag_q   <= '0;
      phase_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ph_q    <= ph_d;
      k_q     <= k_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  // Next state: accept + pre-rotate into the right half-plane, one micro-rotation per cycle, then publish.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ph_d    = ph_q;
    k_d     = k_q;
    mag_d   = mag_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_stb) begin
          state_d = S_ITER;
          k_d     = '0;
          if (i_xval[IW-1]) begin
            x_d  = -ex;
            y_d  = -ey;
            ph_d = HALF_TURN;
          end else begin
            x_d  = ex;
            y_d  = ey;
            ph_d = '0;
          end
        end
      end
      S_ITER: begin
        if (!y_q[WW-1]) begin
          x_d  = x_q + ys;
          y_d  = y_q - xs;
          ph_d = ph_q + ATAN_TBL[k_q];
        end else begin
          x_d  = x_q - ys;
          y_d  = y_q + xs;
          ph_d = ph_q - ATAN_TBL[k_q];
        end
        if (k_q == KW'(NSTAGES - 1)) state_d = S_DONE;
        else                         k_d     = k_q + KW'(1);
      end
      S_DONE: begin
        phase_d = ph_q;
        mag_d   = mag_sat;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;
  assign o_mag   = mag_q;
  assign o_phase = phase_q;

endmodule

// File: tb/tb_cordic_topolar_seq.sv
// Bench for cordic_topolar_seq: directed axis/corner cases, held strobe, mid-conversion reset, random samples.
// Expected magnitude/phase come from real-valued sqrt/atan2 scaled by the CORDIC gain.
// A transaction-level timing model predicts o_busy/o_done and is compared on every cycle.
module tb_cordic_topolar_seq;
  localparam int IW = 12, WW = 16, PW = 24, NST = 14, OW = 13;
  localparam real PI = 3.14159265358979323846;
  localparam int MAG_TOL = 6;
  localparam int PH_TOL  = 32'h2000;

  logic clk = 1'b0;
  logic rst, stb;
  logic signed [IW-1:0] xin, yin;
  logic busy, done;
  logic [OW-1:0] mag;
  logic [PW-1:0] phase;

  int checks = 0;
  int failures = 0;

  cordic_topolar_seq #(.IW(IW), .WW(WW), .PW(PW), .NSTAGES(NST), .OW(OW)) dut (
    .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_xval(xin), .i_yval(yin),
    .o_busy(busy), .o_done(done), .o_mag(mag), .o_phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int model_mag(input int x, input int y);
    real k, m;
    k = 1.0;
    for (int i = 0; i < NST; i++) k = k * $sqrt(1.0 + 1.0 / (4.0 ** i));
    m = k * $sqrt(real'(x * x + y * y));
    if (m > 8191.0) m = 8191.0;
    return int'(m);
  endfunction

  function automatic longint model_ph(input int x, input int y);
    real p;
    longint v;
    p = $atan2(real'(y), real'(x)) / (2.0 * PI);
    if (p < 0.0) p = p + 1.0;
    v = longint'(p * 16777216.0);
    if (v >= 64'd16777216) v = v - 64'd16777216;
    return v;
  endfunction

  function automatic int pdiff(input longint a, input longint b);
    longint d;
    d = (a - b) % 64'd16777216;
    if (d < 0) d = d + 64'd16777216;
    if (d >= 64'd8388608) d = d - 64'd16777216;
    return int'(d);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Transaction-level model: accepted samples finish NST+1 edges later.
  int     cyc = 0;
  bit     m_on = 0, pend = 0, fin, e_busy = 0, e_done = 0, e_zero = 1;
  int     due, px, py, e_mag;
  longint e_ph;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_on = 1; pend = 0; e_busy = 0; e_done = 0; e_zero = 1;
    end else if (m_on) begin
      e_done = 0;
      fin = 0;
      if (pend && cyc == due) begin
        pend = 0; fin = 1; e_done = 1; e_zero = 0;
        e_mag = model_mag(px, py);
        e_ph  = model_ph(px, py);
      end
      if (!pend && !fin && stb) begin
        pend = 1; due = cyc + NST + 1;
        px = xin; py = yin;
      end
      e_busy = pend;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("busy", busy == e_busy, busy, e_busy);
      chk("done", done == e_done, done, e_done);
      if (e_zero) begin
        chk("mag_zero", mag == 0, mag, 0);
        chk("phase_zero", phase == 0, phase, 0);
      end else begin
        chk("mag_model", iabs(int'(mag) - e_mag) <= MAG_TOL, mag, e_mag);
        chk("phase_model", iabs(pdiff(phase, e_ph)) <= PH_TOL, phase, e_ph);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_idle_timeout"}, !busy, busy, 0);
  endtask

  // One conversion: checks latency and, when lit is set, hand-computed expectations.
  task automatic run_one(input string nm, input int x, input int y, input bit lit,
                         input int lm, input int mt, input longint lp, input int pt);
    int n;
    wait_idle(nm);
    stb = 1; xin = IW'(x); yin = IW'(y);
    @(posedge clk); #2 stb = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 40);
    chk({nm, "_latency"}, n == NST + 2, n, NST + 2);
    if (lit) begin
      chk({nm, "_mag_lit"}, iabs(int'(mag) - lm) <= mt, mag, lm);
      chk({nm, "_phase_lit"}, iabs(pdiff(phase, lp)) <= pt, phase, lp);
      chk({nm, "_model_mag_pin"}, iabs(model_mag(x, y) - lm) <= 1, model_mag(x, y), lm);
      chk({nm, "_model_ph_pin"}, iabs(pdiff(model_ph(x, y), lp)) <= 2, model_ph(x, y), lp);
    end
  endtask

  task automatic rnd_xy(output int x, output int y);
    do begin
      x = int'($urandom_range(4095)) - 2048;
      y = int'($urandom_range(4095)) - 2048;
    end while (x * x + y * y < 1024 * 1024);
  endtask

  initial begin
    int x, y;
    int dts[$];
    rst = 1; stb = 0; xin = '0; yin = '0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    repeat (20) @(negedge clk);
    chk("idle_busy", busy == 0, busy, 0);
    chk("idle_mag", mag == 0, mag, 0);

    run_one("pos_x",  1000,     0, 1, 1647, 2, 64'h000000, 32'h1000);
    run_one("pos_y",     0,  1000, 1, 1647, 2, 64'h400000, 32'h1000);
    run_one("neg_x", -1000,     0, 1, 1647, 2, 64'h800000, 32'h1000);
    run_one("neg_y",     0, -1000, 1, 1647, 2, 64'hC00000, 32'h1000);
    run_one("corner", -2048, -2048, 1, 4770, 3, 64'hA00000, 32'h1000);

    // Strobe held high with fresh data every cycle: only idle-edge samples are taken.
    wait_idle("held");
    stb = 1; rnd_xy(x, y); xin = IW'(x); yin = IW'(y);
    repeat (70) begin
      @(posedge clk); #2 rnd_xy(x, y); xin = IW'(x); yin = IW'(y);
      @(negedge clk);
      if (done) dts.push_back(cyc);
    end
    stb = 0;
    chk("held_pulse_count", dts.size() >= 3, dts.size(), 3);
    for (int i = 1; i < dts.size(); i++)
      chk("held_spacing", dts[i] - dts[i-1] == NST + 2, dts[i] - dts[i-1], NST + 2);

    // Reset landing on the edge that would perform iteration k=5.
    wait_idle("rst_mid");
    stb = 1; xin = IW'(500); yin = IW'(900);
    @(posedge clk); #2 stb = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("rst_mid_busy", busy == 0, busy, 0);
    chk("rst_mid_done", done == 0, done, 0);
    chk("rst_mid_mag", mag == 0, mag, 0);
    chk("rst_mid_phase", phase == 0, phase, 0);
    repeat (20) @(negedge clk);
    run_one("after_rst", -1000, 0, 1, 1647, 2, 64'h800000, 32'h1000);

    // Random samples with random idle gaps.
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(5)) @(negedge clk);
      rnd_xy(x, y);
      run_one("rand", x, y, 0, 0, 0, 0, 0);
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
